// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    // Tracker entries store rd at a fixed width wide enough for any legal
    // REG_ADDR_W; narrower indices are zero-extended on entry and compare.
    localparam int TRK_RD_W = 8;

    // Select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [TRK_RD_W-1:0] rd;
        logic                is_load;
    } trk_entry_t;

    // Select width: stages 1..depth plus the register-file code 0.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher: youngest (lowest-index) tracker stage whose rd equals rs.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: en (operand live), rs (source index), entries (stage 1..DEPTH),
//        hit / stage / is_load describe the winning producer.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = 2
) (
    input  logic                     en,
    input  logic [REG_ADDR_W-1:0]    rs,
    input  trk_entry_t [DEPTH:1]     entries,
    output logic                     hit,
    output logic [SEL_W-1:0]         stage,
    output logic                     is_load
);

    logic rs_live;
    assign rs_live = en && (rs != '0);

    // Scan oldest to youngest so the youngest match is the last write.
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rs_live && entries[k].valid &&
                (entries[k].rd == TRK_RD_W'(rs))) begin
                hit     = 1'b1;
                stage   = SEL_W'(k);
                is_load = entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// DEPTH-stage operand forwarding and load-use hazard detection for the ID stage.
// Latency: selects/stall combinational from ID inputs; tracker updates each edge.
// Backpressure: STALL_IN freezes the tracker; LOAD_USE_STALL holds IF/ID for one bubble.
// Ports: CLK, RESET_N (async low); ID_* describe the instruction in decode;
//        FLUSH kills it; FWD_SEL_RS1/2 (0 = regfile, k = stage k); LOAD_USE_STALL;
//        FWD_COUNT/STALL_COUNT perf counters, live only with HAZARD_FWD_STATS_EN.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = sel_width(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  ID_REG_WRITE,
    input  logic                  ID_IS_LOAD,
    input  logic                  STALL_IN,
    input  logic                  FLUSH,
    output logic [SEL_W-1:0]      FWD_SEL_RS1,
    output logic [SEL_W-1:0]      FWD_SEL_RS2,
    output logic                  LOAD_USE_STALL,
    output logic [31:0]           FWD_COUNT,
    output logic [31:0]           STALL_COUNT
);

    trk_entry_t [DEPTH:1] trk_q;
    trk_entry_t           ins_entry;

    logic             m1_hit, m2_hit, m1_ld, m2_ld;
    logic [SEL_W-1:0] m1_stage, m2_stage;
    logic             load_use_raw;
    logic             load_use;
    logic             bubble;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs1 (
        .en      (ID_VALID && ID_USES_RS1),
        .rs      (ID_RS1),
        .entries (trk_q),
        .hit     (m1_hit),
        .stage   (m1_stage),
        .is_load (m1_ld)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_rs2 (
        .en      (ID_VALID && ID_USES_RS2),
        .rs      (ID_RS2),
        .entries (trk_q),
        .hit     (m2_hit),
        .stage   (m2_stage),
        .is_load (m2_ld)
    );

    // A load one stage ahead has no result yet. Stage 1 always wins priority,
    // so the winner's is_load is the stage-1 entry's flag.
    assign load_use_raw = (m1_hit && (m1_stage == SEL_W'(1)) && m1_ld) ||
                          (m2_hit && (m2_stage == SEL_W'(1)) && m2_ld);
    // A flushed instruction never consumes its operands, so it cannot stall.
    assign load_use       = load_use_raw && ID_VALID && !FLUSH;
    assign LOAD_USE_STALL = load_use;

    assign FWD_SEL_RS1 = load_use ? SEL_W'(FWD_SEL_RF) : m1_stage;
    assign FWD_SEL_RS2 = load_use ? SEL_W'(FWD_SEL_RF) : m2_stage;

    assign bubble = FLUSH || load_use || !ID_VALID;

    always_comb begin
        ins_entry = '0;
        if (!bubble) begin
            ins_entry.valid   = ID_REG_WRITE && (ID_RD != '0);
            ins_entry.rd      = TRK_RD_W'(ID_RD);
            ins_entry.is_load = ID_IS_LOAD;
        end
    end

    // Under STALL_IN everything holds, including any pending FLUSH; upstream
    // keeps FLUSH asserted until the hold releases.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            trk_q <= '0;
        end else if (!STALL_IN) begin
            for (int k = DEPTH; k >= 2; k--) begin
                trk_q[k] <= trk_q[k-1];
            end
            trk_q[1] <= ins_entry;
        end
    end

`ifdef HAZARD_FWD_STATS_EN
    logic [31:0] fwd_cnt_q, stall_cnt_q;
    logic        fwd_any;

    assign fwd_any = (FWD_SEL_RS1 != '0) || (FWD_SEL_RS2 != '0);

    // Saturating counters: stop at all-ones rather than wrap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!STALL_IN && fwd_any && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
            if (load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign FWD_COUNT   = fwd_cnt_q;
    assign STALL_COUNT = stall_cnt_q;
`else
    assign FWD_COUNT   = '0;
    assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: DEPTH=3 and DEPTH=2 instances share stimulus.
// Latency: checks sampled on the falling edge, inputs driven 1ns after the rising edge.
// Backpressure: STALL_IN/FLUSH exercised through the vector table.
module tb_hazard_forward_unit;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       stall_in, flush;

    logic [1:0]  sel1_d3, sel2_d3, sel1_d2, sel2_d2;
    logic        lus_d3, lus_d2;
    logic [31:0] fwd_cnt_d3, stall_cnt_d3, fwd_cnt_d2, stall_cnt_d2;

    always #5 CLK = ~CLK;

    hazard_forward_unit #(.REG_ADDR_W(5), .DEPTH(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ID_VALID(id_valid),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
        .ID_RD(id_rd), .ID_REG_WRITE(id_reg_write), .ID_IS_LOAD(id_is_load),
        .STALL_IN(stall_in), .FLUSH(flush),
        .FWD_SEL_RS1(sel1_d3), .FWD_SEL_RS2(sel2_d3), .LOAD_USE_STALL(lus_d3),
        .FWD_COUNT(fwd_cnt_d3), .STALL_COUNT(stall_cnt_d3)
    );

    hazard_forward_unit #(.REG_ADDR_W(5), .DEPTH(2)) dut_d2 (
        .CLK(CLK), .RESET_N(RESET_N), .ID_VALID(id_valid),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2),
        .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
        .ID_RD(id_rd), .ID_REG_WRITE(id_reg_write), .ID_IS_LOAD(id_is_load),
        .STALL_IN(stall_in), .FLUSH(flush),
        .FWD_SEL_RS1(sel1_d2), .FWD_SEL_RS2(sel2_d2), .LOAD_USE_STALL(lus_d2),
        .FWD_COUNT(fwd_cnt_d2), .STALL_COUNT(stall_cnt_d2)
    );

    typedef struct {
        logic       vld;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, ld, stl, fl;
        int         s1, s2, lus;   // expected, DEPTH=3
        int         d2s1, d2s2;    // expected selects, DEPTH=2
    } vec_t;

    localparam int NVEC = 31;
    vec_t tbl [NVEC];

    int n_chk  = 0;
    int n_fail = 0;
    int exp_fwd_cnt   = 0;
    int exp_stall_cnt = 0;

    function automatic vec_t mk(input logic vld, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic rw, input logic ld, input logic stl,
                                input logic fl, input int s1, input int s2,
                                input int lus, input int d2s1, input int d2s2);
        vec_t v;
        v.vld = vld; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.rw = rw; v.ld = ld; v.stl = stl; v.fl = fl;
        v.s1 = s1; v.s2 = s2; v.lus = lus; v.d2s1 = d2s1; v.d2s2 = d2s2;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid     = v.vld;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_uses_rs1  = v.u1;
        id_uses_rs2  = v.u2;
        id_rd        = v.rd;
        id_reg_write = v.rw;
        id_is_load   = v.ld;
        stall_in     = v.stl;
        flush        = v.fl;
    endtask

    initial begin
        int stats_on;
        vec_t v;
`ifdef HAZARD_FWD_STATS_EN
        stats_on = 1;
`else
        stats_on = 0;
`endif
        //           vld rs1 rs2 u1 u2 rd rw ld st fl  s1 s2 lus d2s1 d2s2
        tbl[0]  = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0); // idle
        tbl[1]  = mk(1,  1,  2,  1, 1, 5, 1, 0, 0, 0,  0, 0, 0,  0, 0); // add x5
        tbl[2]  = mk(1,  5,  5,  1, 1, 6, 1, 0, 0, 0,  1, 1, 0,  1, 1); // add x6,x5,x5
        tbl[3]  = mk(1,  3,  4,  1, 1, 7, 1, 0, 0, 0,  0, 0, 0,  0, 0); // producer x7
        tbl[4]  = mk(1,  1,  2,  1, 1,11, 1, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[5]  = mk(1,  1,  2,  1, 1,12, 1, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[6]  = mk(1,  7,  0,  1, 1,13, 1, 0, 0, 0,  3, 0, 0,  0, 0); // x7 at stage 3
        tbl[7]  = mk(1,  1,  0,  1, 0, 8, 1, 1, 0, 0,  0, 0, 0,  0, 0); // lw x8
        tbl[8]  = mk(1,  8,  1,  1, 1, 9, 1, 0, 0, 0,  0, 0, 1,  0, 0); // load-use
        tbl[9]  = mk(1,  8,  1,  1, 1, 9, 1, 0, 0, 0,  2, 0, 0,  2, 0); // after bubble
        tbl[10] = mk(1,  1,  2,  1, 1,10, 1, 0, 0, 0,  0, 0, 0,  0, 0); // x10 writer
        tbl[11] = mk(1,  3,  4,  1, 1,15, 1, 0, 0, 0,  0, 0, 0,  0, 0);
        tbl[12] = mk(1,  3,  4,  1, 1,10, 1, 0, 0, 0,  0, 0, 0,  0, 0); // x10 again
        tbl[13] = mk(1, 10, 10,  1, 1,16, 1, 0, 0, 0,  1, 1, 0,  1, 1); // youngest wins
        tbl[14] = mk(1,  1,  2,  1, 1, 0, 1, 0, 0, 0,  0, 0, 0,  0, 0); // writes x0
        tbl[15] = mk(1,  0,  0,  1, 1,17, 1, 0, 0, 0,  0, 0, 0,  0, 0); // reads x0
        tbl[16] = mk(1, 17, 16,  0, 1, 0, 0, 0, 0, 0,  0, 3, 0,  0, 0); // rs1 unused
        tbl[17] = mk(0, 17, 17,  1, 1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0); // not valid
        tbl[18] = mk(1,  1,  2,  1, 1,20, 1, 0, 0, 0,  0, 0, 0,  0, 0); // producer x20
        tbl[19] = mk(1, 20,  3,  1, 1,21, 1, 0, 1, 0,  1, 0, 0,  1, 0); // held x3
        tbl[20] = mk(1, 20,  3,  1, 1,21, 1, 0, 1, 0,  1, 0, 0,  1, 0);
        tbl[21] = mk(1, 20,  3,  1, 1,21, 1, 0, 1, 0,  1, 0, 0,  1, 0);
        tbl[22] = mk(1, 20,  3,  1, 1,21, 1, 0, 0, 0,  1, 0, 0,  1, 0);
        tbl[23] = mk(1,  1,  0,  1, 0,22, 1, 1, 0, 0,  0, 0, 0,  0, 0); // lw x22
        tbl[24] = mk(1, 22, 20,  1, 1,23, 1, 0, 0, 1,  1, 3, 0,  1, 0); // flush masks
        tbl[25] = mk(1, 23, 22,  1, 1,24, 1, 0, 0, 0,  0, 2, 0,  0, 2); // bubble seen
        tbl[26] = mk(1,  1,  0,  1, 0,25, 1, 1, 0, 0,  0, 0, 0,  0, 0); // lw x25
        tbl[27] = mk(1,  1, 25,  1, 1,26, 1, 0, 1, 0,  0, 0, 1,  0, 0); // lu + hold
        tbl[28] = mk(1,  1, 25,  1, 1,26, 1, 0, 0, 0,  0, 0, 1,  0, 0);
        tbl[29] = mk(1,  1, 25,  1, 1,26, 1, 0, 0, 0,  0, 2, 0,  0, 2);
        tbl[30] = mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);

        RESET_N = 1'b0;
        drive(tbl[0]);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset sel1", int'(sel1_d3), 0);
        chk("reset sel2", int'(sel2_d3), 0);
        chk("reset stall", int'(lus_d3), 0);
        chk("reset fwd_count", int'(fwd_cnt_d3), 0);
        chk("reset stall_count", int'(stall_cnt_d3), 0);
        #2 RESET_N = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge CLK);
            #1 drive(tbl[i]);
            @(negedge CLK);
            chk($sformatf("row%0d sel1", i), int'(sel1_d3), tbl[i].s1);
            chk($sformatf("row%0d sel2", i), int'(sel2_d3), tbl[i].s2);
            chk($sformatf("row%0d stall", i), int'(lus_d3), tbl[i].lus);
            chk($sformatf("row%0d d2 sel1", i), int'(sel1_d2), tbl[i].d2s1);
            chk($sformatf("row%0d d2 sel2", i), int'(sel2_d2), tbl[i].d2s2);
            if (!tbl[i].stl && (tbl[i].s1 != 0 || tbl[i].s2 != 0)) exp_fwd_cnt++;
            if (tbl[i].lus != 0) exp_stall_cnt++;
        end

        @(posedge CLK);
        #1;
        chk("fwd_count after table", int'(fwd_cnt_d3), stats_on * exp_fwd_cnt);
        chk("stall_count after table", int'(stall_cnt_d3), stats_on * exp_stall_cnt);

        // Reset asserted mid-hold with a load-use hazard pending.
        v = mk(1, 1, 0, 1, 0, 27, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(posedge CLK);
        #1;
        v = mk(1, 27, 0, 1, 1, 28, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(negedge CLK);
        chk("pre-reset stall", int'(lus_d3), 1);
        #1 RESET_N = 1'b0;
        #1;
        chk("async reset sel1", int'(sel1_d3), 0);
        chk("async reset sel2", int'(sel2_d3), 0);
        chk("async reset stall", int'(lus_d3), 0);
        chk("async reset fwd_count", int'(fwd_cnt_d3), 0);
        chk("async reset stall_count", int'(stall_cnt_d3), 0);
        #1;
        stall_in = 1'b0;
        RESET_N  = 1'b1;
        @(posedge CLK);
        #1;
        v = mk(1, 28, 28, 1, 1, 29, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        @(negedge CLK);
        chk("post-reset sel1", int'(sel1_d3), 1);
        chk("post-reset sel2", int'(sel2_d3), 1);
        chk("post-reset stall", int'(lus_d3), 0);
        @(posedge CLK);
        #1;
        chk("post-reset fwd_count", int'(fwd_cnt_d3), stats_on);
        chk("post-reset stall_count", int'(stall_cnt_d3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
